// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte-to-word address conversion,
// lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ,
    input  logic [2:0]  OP,
    input  logic [31:0] ADDR_IN,
    input  logic [31:0] STORE_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] LOAD_DATA,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic [1:0]  r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_sdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_load_data;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_misaligned;
    logic        w_out_of_range;
    logic [31:0] w_hi_bits;
    logic [31:0] w_word_addr;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    always_comb begin
        w_misaligned = 1'b0;
        case (OP)
            OP_LW, OP_SW:         w_misaligned = (ADDR_IN[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_misaligned = ADDR_IN[0];
            default:              w_misaligned = 1'b0;
        endcase
        // Any address bit above the memory range is rejected rather than aliased.
        w_hi_bits      = ADDR_IN >> (DEPTH_LOG2 + 2);
        w_out_of_range = (w_hi_bits != '0);
        w_word_addr    = (ADDR_IN & ((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1)) >> 2;
    end

    always_comb begin
        w_shift = {r_lane, 3'b000};
        w_byte  = 8'(MEM_RDATA >> w_shift);
        w_half  = r_lane[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (r_op)
            OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
            OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
            OP_LBU:  w_load_val = {24'h0, w_byte};
            OP_LHU:  w_load_val = {16'h0, w_half};
            default: w_load_val = MEM_RDATA;
        endcase
        if (r_op == OP_SB) begin
            w_merged = (MEM_RDATA & ~(32'h0000_00FF << w_shift)) | ({24'h0, r_sdata[7:0]} << w_shift);
        end else begin
            w_merged = (MEM_RDATA & ~(32'h0000_FFFF << w_shift)) | ({16'h0, r_sdata} << w_shift);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_lane      <= '0;
            r_sdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_load_data <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_op    <= OP;
                        r_lane  <= ADDR_IN[1:0];
                        r_sdata <= STORE_DATA[15:0];
                        r_busy  <= 1'b1;
                        if (w_misaligned || w_out_of_range) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_mem_addr <= w_word_addr;
                            if (OP == OP_SW) begin
                                r_state     <= S_WRITE;
                                r_mem_write <= 1'b1;
                                r_mem_wdata <= STORE_DATA;
                            end else begin
                                r_state    <= S_READ;
                                r_mem_read <= 1'b1;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (r_op < OP_SB) begin
                        r_load_data <= w_load_val;
                        r_state     <= S_FINISH;
                        r_done      <= 1'b1;
                    end else begin
                        r_mem_wdata <= w_merged;
                        r_mem_write <= 1'b1;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state <= S_FINISH;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign LOAD_DATA = r_load_data;
    assign MEM_READ  = r_mem_read;
    assign MEM_WRITE = r_mem_write;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_load_store_unit;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
    localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQ = 1'b0;
    logic [2:0]  OP = '0;
    logic [31:0] ADDR_IN = '0;
    logic [31:0] STORE_DATA = '0;
    logic        BUSY, DONE, ERR, MEM_READ, MEM_WRITE;
    logic [31:0] LOAD_DATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;

    logic [31:0] tb_mem  [32];
    logic [31:0] ref_mem [32];

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.DEPTH_LOG2(5)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .OP(OP), .ADDR_IN(ADDR_IN),
        .STORE_DATA(STORE_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .LOAD_DATA(LOAD_DATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    assign MEM_RDATA = tb_mem[MEM_ADDR[4:0]];
    always @(negedge CLK) if (MEM_WRITE) tb_mem[MEM_ADDR[4:0]] <= MEM_WDATA;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per transaction, a remaining-cycle count and the final results.
    int          cnt = 0;
    int          m_len = 0;
    logic        m_err = 1'b0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_new = '0;
    logic [31:0] m_load = '0;
    logic [31:0] exp_load = '0;

    always @(posedge CLK or negedge RESET_N) begin
        logic [31:0] sz;
        logic [31:0] w;
        logic [1:0]  off;
        logic [7:0]  by [4];
        if (!RESET_N) begin
            cnt      = 0;
            exp_load = '0;
        end else if (cnt > 0) begin
            if (cnt == 2 && !m_err) begin
                if (m_op >= SB) ref_mem[m_word[4:0]] = m_new;
                else            exp_load = m_load;
            end
            cnt--;
        end else if (REQ) begin
            m_op   = OP;
            sz     = (OP == LB || OP == LBU || OP == SB) ? 32'd1 :
                     (OP == LH || OP == LHU || OP == SH) ? 32'd2 : 32'd4;
            m_err  = ((ADDR_IN % sz) != 32'd0) || (ADDR_IN > 32'h7F);
            m_word = ADDR_IN / 32'd4;
            off    = ADDR_IN[1:0];
            m_len  = m_err ? 1 : (OP == SB || OP == SH) ? 3 : 2;
            cnt    = m_len;
            if (!m_err) begin
                w = ref_mem[m_word[4:0]];
                for (int k = 0; k < 4; k++) by[k] = 8'(w >> (8 * k));
                case (OP)
                    LB:  m_load = {{24{by[off][7]}}, by[off]};
                    LH:  m_load = {{16{by[off + 2'd1][7]}}, by[off + 2'd1], by[off]};
                    LW:  m_load = w;
                    LBU: m_load = {24'h0, by[off]};
                    LHU: m_load = {16'h0, by[off + 2'd1], by[off]};
                    SB:  by[off] = STORE_DATA[7:0];
                    SH:  begin by[off] = STORE_DATA[7:0]; by[off + 2'd1] = STORE_DATA[15:8]; end
                    default: for (int k = 0; k < 4; k++) by[k] = 8'(STORE_DATA >> (8 * k));
                endcase
                m_new = {by[3], by[2], by[1], by[0]};
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET_N) begin
            chk("rst_busy", BUSY, 0);
            chk("rst_done", DONE, 0);
            chk("rst_err", ERR, 0);
            chk("rst_rd", MEM_READ, 0);
            chk("rst_wr", MEM_WRITE, 0);
            chk("rst_load", LOAD_DATA, 0);
            chk("rst_addr", MEM_ADDR, 0);
            chk("rst_wdata", MEM_WDATA, 0);
        end else begin
            logic e_rd, e_wr;
            e_rd = (cnt != 0) && (cnt == m_len) && !m_err && (m_op != SW);
            e_wr = (cnt == 2) && !m_err && (m_op >= SB);
            chk("busy", BUSY, 32'(cnt != 0));
            chk("done", DONE, 32'(cnt == 1));
            chk("err", ERR, 32'(cnt == 1 && m_err));
            chk("mem_read", MEM_READ, 32'(e_rd));
            chk("mem_write", MEM_WRITE, 32'(e_wr));
            chk("load_data", LOAD_DATA, exp_load);
            if (e_rd || e_wr) chk("mem_addr", MEM_ADDR, m_word);
            if (e_wr) chk("mem_wdata", MEM_WDATA, m_new);
        end
    end

    int          t_lat;
    logic        t_err, t_rd, t_wr, t_done;
    logic [31:0] t_wd, t_wa;

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        #1 REQ = 1'b1; OP = op; ADDR_IN = addr; STORE_DATA = data;
        @(posedge CLK);
        #1 REQ = 1'b0;
        t_lat = 0; t_err = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_done = 1'b0; t_wd = '0; t_wa = '0;
        for (int i = 0; i < 10 && !t_done; i++) begin
            @(negedge CLK);
            t_lat++;
            if (MEM_READ) t_rd = 1'b1;
            if (MEM_WRITE) begin t_wr = 1'b1; t_wd = MEM_WDATA; t_wa = MEM_ADDR; end
            if (DONE) begin t_done = 1'b1; t_err = ERR; end
        end
        chk("done_seen", t_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn [$];
        for (int i = 0; i < 32; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        repeat (3) @(negedge CLK);
        #1 RESET_N = 1'b1;

        // 1: SW then LW
        do_req(SW, 32'h08, 32'hDEADBEEF);
        chk("t1_sw_lat", t_lat, 2); chk("t1_sw_err", t_err, 0);
        chk("t1_sw_wr", t_wr, 1); chk("t1_sw_rd", t_rd, 0);
        chk("t1_sw_addr", t_wa, 2); chk("t1_sw_wd", t_wd, 32'hDEADBEEF);
        chk("t1_mem", tb_mem[2], 32'hDEADBEEF);
        do_req(LW, 32'h08, 32'h0);
        chk("t1_lw_lat", t_lat, 2); chk("t1_lw_err", t_err, 0);
        chk("t1_lw_data", LOAD_DATA, 32'hDEADBEEF);

        // 2: sub-word loads
        do_req(LB, 32'h0B, 32'h0);  chk("t2_lb", LOAD_DATA, 32'hFFFFFFDE);
        do_req(LBU, 32'h0B, 32'h0); chk("t2_lbu", LOAD_DATA, 32'h000000DE);
        do_req(LH, 32'h08, 32'h0);  chk("t2_lh", LOAD_DATA, 32'hFFFFBEEF);
        do_req(LHU, 32'h0A, 32'h0); chk("t2_lhu", LOAD_DATA, 32'h0000DEAD);
        chk("t2_lhu_lat", t_lat, 2);

        // 3: read-modify-write stores
        do_req(SB, 32'h09, 32'hAAAA_AA12);
        chk("t3_sb_lat", t_lat, 3); chk("t3_sb_rd", t_rd, 1);
        chk("t3_sb_wd", t_wd, 32'hDEAD12EF); chk("t3_sb_mem", tb_mem[2], 32'hDEAD12EF);
        do_req(SH, 32'h0A, 32'hBBBB_5678);
        chk("t3_sh_lat", t_lat, 3); chk("t3_sh_wd", t_wd, 32'h567812EF);
        chk("t3_sh_mem", tb_mem[2], 32'h567812EF);
        chk("t3_load_kept", LOAD_DATA, 32'h0000DEAD);

        // 4: rejected accesses
        do_req(LW, 32'h06, 32'h0);
        chk("t4_lw6_lat", t_lat, 1); chk("t4_lw6_err", t_err, 1);
        chk("t4_lw6_strobe", {t_rd, t_wr}, 0);
        do_req(SH, 32'h03, 32'hFFFF);
        chk("t4_sh3_lat", t_lat, 1); chk("t4_sh3_err", t_err, 1);
        chk("t4_sh3_strobe", {t_rd, t_wr}, 0);
        do_req(LW, 32'h80, 32'h0);
        chk("t4_lw80_lat", t_lat, 1); chk("t4_lw80_err", t_err, 1);
        chk("t4_lw80_strobe", {t_rd, t_wr}, 0);
        chk("t4_load_kept", LOAD_DATA, 32'h0000DEAD);
        chk("t4_mem_kept", tb_mem[2], 32'h567812EF);

        // 5: REQ held high
        @(negedge CLK);
        #1 REQ = 1'b1; OP = LW; ADDR_IN = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (DONE) begin
                dn.push_back(c);
                chk("t5_busy_in_done", BUSY, 1);
            end
        end
        #1 REQ = 1'b0;
        chk("t5_pulses", dn.size(), 4);
        if (dn.size() > 0) chk("t5_first", dn[0], 2);
        for (int i = 1; i < dn.size(); i++) chk("t5_period", dn[i] - dn[i - 1], 3);
        chk("t5_data", LOAD_DATA, 32'h1000_0000);

        // 6: reset during the READ of an SB
        @(negedge CLK);
        #1 REQ = 1'b1; OP = SB; ADDR_IN = 32'h0C; STORE_DATA = 32'h77;
        @(posedge CLK);
        #1 REQ = 1'b0;
        chk("t6_in_read", MEM_READ, 1);
        #1 RESET_N = 1'b0;
        #1 chk("t6_busy", BUSY, 0); chk("t6_rd", MEM_READ, 0); chk("t6_load", LOAD_DATA, 0);
        repeat (2) begin
            @(negedge CLK);
            chk("t6_no_write", MEM_WRITE, 0);
        end
        #1 RESET_N = 1'b1;
        do_req(LW, 32'h0C, 32'h0);
        chk("t6_lw_lat", t_lat, 2); chk("t6_lw_err", t_err, 0);
        chk("t6_lw_data", LOAD_DATA, 32'h1000_0003);

        repeat (2) @(negedge CLK);
        for (int i = 0; i < 32; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
